// File: rtl/mem_dma_if.sv
// ============================================================================
// mem_dma_if : control handshake and memory port bundle for mem_dma
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_dma_if #(
  parameter int LEN_W = 7
);
  logic             start;
  logic             mode;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic [31:0]      fill_val;
  logic [31:0]      mem_rd;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      checksum;

  // master is the DMA engine itself; slave is the requester plus the memory
  modport master (
    input  start, mode, src, dst, len, fill_val, mem_rd,
    output mem_we, mem_a, mem_wd, busy, done, err, checksum
  );

  modport slave (
    output start, mode, src, dst, len, fill_val, mem_rd,
    input  mem_we, mem_a, mem_wd, busy, done, err, checksum
  );
endinterface

`default_nettype wire

// File: rtl/mem_dma.sv
// ============================================================================
// mem_dma : memory-side initiator performing block copy / block fill
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_dma #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 7
) (
  input  logic      clk,
  input  logic      reset,
  mem_dma_if.master bus
);

  localparam logic [32:0] C_LIMIT = 33'(DEPTH * 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      fill_q, fill_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      last_a_q, last_a_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [32:0]      w_dst_end;
  logic [32:0]      w_src_end;
  logic             w_bad;
  logic [31:0]      w_wr_word;

  // 33-bit end addresses so a request near the top of the address space cannot wrap
  assign w_dst_end = {1'b0, bus.dst} + {{(31 - LEN_W){1'b0}}, bus.len, 2'b00};
  assign w_src_end = {1'b0, bus.src} + {{(31 - LEN_W){1'b0}}, bus.len, 2'b00};

  assign w_bad = (bus.dst[1:0] != 2'b00)
              || (!bus.mode && (bus.src[1:0] != 2'b00))
              || (w_dst_end > C_LIMIT)
              || (!bus.mode && (w_src_end > C_LIMIT));

  assign w_wr_word = mode_q ? fill_q : data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      sum_q    <= '0;
      last_a_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      sum_q    <= sum_d;
      last_a_q <= last_a_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    fill_d   = fill_q;
    data_d   = data_q;
    sum_d    = sum_q;
    last_a_d = last_a_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d = bus.mode;
          src_d  = bus.src;
          dst_d  = bus.dst;
          fill_d = bus.fill_val;
          cnt_d  = bus.len;
          sum_d  = '0;
          if (w_bad) begin
            state_d = S_ERR;
          end else if (bus.len == '0) begin
            state_d = S_DONE;
          end else if (bus.mode) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        data_d   = bus.mem_rd;
        last_a_d = src_q;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        sum_d    = sum_q + w_wr_word;
        src_d    = src_q + 32'd4;
        dst_d    = dst_q + 32'd4;
        cnt_d    = cnt_q - LEN_W'(1);
        last_a_d = dst_q;
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; mem_a keeps the last address driven while the port is not in use
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_a    = last_a_q;
    bus.mem_wd   = '0;
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.err      = (state_q == S_ERR);
    bus.checksum = sum_q;
    case (state_q)
      S_READ: begin
        bus.mem_a = src_q;
      end
      S_WRITE: begin
        bus.mem_we = 1'b1;
        bus.mem_a  = dst_q;
        bus.mem_wd = w_wr_word;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_dma.sv
// ============================================================================
// tb_mem_dma : randomized scoreboard bench for mem_dma with a word-array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_dma;

  localparam int DEPTH = 64;
  localparam int LEN_W = 7;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    bit          is_err;
    logic [31:0] cs;
    int          lat;
    int          wes;
    longint      t0;
    int          we0;
  } xfer_t;

  typedef struct {
    logic [31:0] cs;
    logic [31:0] a;
  } snap_t;

  logic           clk    = 1'b0;
  logic           reset  = 1'b1;
  logic           bd_we  = 1'b0;
  logic [AW-1:0]  bd_idx = '0;
  logic [31:0]    bd_val = '0;
  logic [31:0]    mem     [0:DEPTH-1];
  logic [31:0]    ref_mem [0:DEPTH-1];
  xfer_t          xq[$];
  snap_t          sq[$];
  longint         cyc      = 0;
  int             we_total = 0;
  int             checks   = 0;
  int             errors   = 0;

  mem_dma_if #(.LEN_W(LEN_W)) bus ();

  mem_dma #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, posedge write, plus a backdoor for preloading
  assign bus.mem_rd = mem[bus.mem_a[AW+1:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) mem[bd_idx] <= bd_val;
    else if (bus.mem_we) mem[bus.mem_a[AW+1:2]] <= bus.mem_wd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin : p_mon
    xfer_t e;
    snap_t s;
    if (bus.mem_we) we_total = we_total + 1;

    if (sq.size() != 0) begin
      s = sq.pop_front();
      chk("idle_busy",     32'(bus.busy),   32'd0);
      chk("idle_done_err", 32'({bus.done, bus.err}), 32'd0);
      chk("idle_mem_we",   32'(bus.mem_we), 32'd0);
      chk("idle_checksum", bus.checksum,    s.cs);
      chk("idle_mem_a",    bus.mem_a,       s.a);
      chk("idle_mem_wd",   bus.mem_wd,      32'd0);
      chk("idle_mem_words_differing", 32'(mem_diff()), 32'd0);
    end

    if (xq.size() != 0 && cyc == xq[0].t0 + 1)
      chk("busy_after_start", 32'(bus.busy), 32'd1);

    if (bus.done || bus.err) begin
      if (xq.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none (cycle %0d)",
                 bus.done, bus.err, cyc);
      end else begin
        e = xq.pop_front();
        chk("result_kind {done,err}", 32'({bus.done, bus.err}), e.is_err ? 32'd1 : 32'd2);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("checksum", bus.checksum, e.cs);
        chk("write_count", 32'(we_total - e.we0), 32'(e.wes));
        chk("mem_words_differing", 32'(mem_diff()), 32'd0);
      end
    end else if (xq.size() != 0 && cyc > xq[0].t0 + longint'(xq[0].lat)) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: no done/err by cycle %0d, required at cycle %0d",
               cyc, xq[0].t0 + longint'(xq[0].lat));
      void'(xq.pop_front());
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = AW'(idx);
    bd_val = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference model: sequential word-by-word transfer applied to ref_mem
  task automatic do_xfer(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                         input logic [LEN_W-1:0] len, input logic [31:0] fv, input bit inject);
    xfer_t       e;
    longint      d_end, s_end;
    int          n;
    logic [31:0] w;
    n     = int'(len);
    d_end = longint'({32'h0, dst}) + 4 * longint'(n);
    s_end = longint'({32'h0, src}) + 4 * longint'(n);
    @(negedge clk);
    e.is_err = (dst % 4 != 0) || (!mode && (src % 4 != 0))
            || (d_end > DEPTH * 4) || (!mode && (s_end > DEPTH * 4));
    e.cs  = 32'h0;
    e.wes = 0;
    e.lat = 1;
    if (!e.is_err && n != 0) begin
      for (int i = 0; i < n; i++) begin
        w = mode ? fv : ref_mem[int'(src / 4) + i];
        ref_mem[int'(dst / 4) + i] = w;
        e.cs = e.cs + w;
      end
      e.wes = n;
      e.lat = mode ? n + 1 : 2 * n + 1;
    end
    e.t0  = cyc;
    e.we0 = we_total;
    bus.start    = 1'b1;
    bus.mode     = mode;
    bus.src      = src;
    bus.dst      = dst;
    bus.len      = len;
    bus.fill_val = fv;
    xq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    if (inject) begin
      bus.start    = 1'b1;
      bus.mode     = ~mode;
      bus.src      = 32'h0;
      bus.dst      = 32'h0;
      bus.len      = LEN_W'(5);
      bus.fill_val = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
    end
    while (xq.size() != 0) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r = int'($urandom_range(0, 15));
    if (r == 0) return 32'hFFFF_FFF0;
    return 32'($urandom_range(0, DEPTH - 1) * 4 + ((r == 1) ? $urandom_range(1, 3) : 0));
  endfunction

  initial begin
    longint t;
    logic [LEN_W-1:0] rl;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.src      = '0;
    bus.dst      = '0;
    bus.len      = '0;
    bus.fill_val = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    sq.push_back('{cs: 32'h0, a: 32'h0});
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) poke(i, 32'h0);
    poke(0, 32'd11); poke(1, 32'd22); poke(2, 32'd33); poke(3, 32'd44);

    // copy with a start pulse landing while busy
    do_xfer(1'b0, 32'h00, 32'h40, LEN_W'(4), 32'h0, 1'b1);
    @(posedge clk);
    sq.push_back('{cs: 32'h0000_006E, a: 32'h0000_004C});
    repeat (2) @(negedge clk);

    do_xfer(1'b1, 32'h0, 32'h80, LEN_W'(3), 32'hDEAD_BEEF, 1'b0);
    do_xfer(1'b1, 32'h0, 32'h42, LEN_W'(1), 32'h1234_5678, 1'b0);
    do_xfer(1'b1, 32'h0, 32'hF8, LEN_W'(3), 32'h5555_AAAA, 1'b0);
    do_xfer(1'b0, 32'h2, 32'h40, LEN_W'(1), 32'h0, 1'b0);
    do_xfer(1'b0, 32'hF0, 32'h00, LEN_W'(8), 32'h0, 1'b0);
    do_xfer(1'b0, 32'h0, 32'h00, LEN_W'(DEPTH), 32'h0, 1'b0);
    do_xfer(1'b1, 32'h0, 32'h10, LEN_W'(0), 32'h77, 1'b1);

    poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3);
    do_xfer(1'b0, 32'h0, 32'h4, LEN_W'(2), 32'h0, 1'b0);

    // reset during the second write of a four-word copy
    poke(0, 32'd11); poke(1, 32'd22); poke(2, 32'd33); poke(3, 32'd44);
    for (int i = 16; i < 20; i++) poke(i, 32'h0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.src   = 32'h0;
    bus.dst   = 32'h40;
    bus.len   = LEN_W'(4);
    t = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t + 4) @(negedge clk);
    reset = 1'b1;
    ref_mem[16] = 32'd11;
    @(posedge clk);
    sq.push_back('{cs: 32'h0, a: 32'h0});
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) rl = LEN_W'(DEPTH);
      else rl = LEN_W'($urandom_range(0, 12));
      do_xfer(1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rl, $urandom,
              ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
